// File: rtl/led_panel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_panel_pkg
// Description : Shared state encoding, pixel layout and bit-plane helper for
//               the HUB75 scan controller.
// Revision    : 1.0  initial release
// ============================================================================
package led_panel_pkg;

    localparam int PIX_W = 12;
    localparam int R_OFS = 8;
    localparam int G_OFS = 4;
    localparam int B_OFS = 0;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_SHIFT    = 3'd2;
    localparam logic [2:0] S_BLANK    = 3'd3;
    localparam logic [2:0] S_LATCH    = 3'd4;
    localparam logic [2:0] S_DISPLAY  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = S_IDLE,
        ST_PREFETCH = S_PREFETCH,
        ST_SHIFT    = S_SHIFT,
        ST_BLANK    = S_BLANK,
        ST_LATCH    = S_LATCH,
        ST_DISPLAY  = S_DISPLAY
    } state_t;

    // Bit 'plane' of each colour channel, packed as {R,G,B}.
    function automatic logic [2:0] plane_rgb(input logic [PIX_W-1:0] pix,
                                             input int unsigned      plane);
        plane_rgb = {|(pix & (PIX_W'(1) << (R_OFS + plane))),
                     |(pix & (PIX_W'(1) << (G_OFS + plane))),
                     |(pix & (PIX_W'(1) << (B_OFS + plane)))};
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_oe_timer.sv
`default_nettype none
// ============================================================================
// Module      : led_oe_timer
// Description : Loadable down-counter timing the output-enable window.
// Revision    : 1.0  initial release
// ============================================================================
module led_oe_timer #(
    parameter int TW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [TW-1:0] i_load,
    output logic          o_done
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= i_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - TW'(1);
        end
    end

    // Done marks the final cycle of the loaded window; the count then rests at 0.
    assign o_done = (r_cnt == TW'(1));

endmodule
`default_nettype wire

// File: rtl/led_panel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_panel_scan_ctrl
// Description : HUB75 row/bit-plane sequencer with binary-coded modulation.
// Revision    : 1.0  initial release
// ============================================================================
module led_panel_scan_ctrl
    import led_panel_pkg::*;
#(
    parameter int COLS      = 64,
    parameter int ROWS_HALF = 32,
    parameter int BPC       = 4,
    parameter int BASE_OE   = 8,
    localparam int CW       = $clog2(COLS),
    localparam int RW       = $clog2(ROWS_HALF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    output logic [RW+CW-1:0] mem_addr,
    input  logic [PIX_W-1:0] pix_top,
    input  logic [PIX_W-1:0] pix_bot,
    output logic             PCLK,
    output logic [2:0]       RGB0,
    output logic [2:0]       RGB1,
    output logic             LATCH,
    output logic             NOE,
    output logic [RW-1:0]    ROW,
    output logic             frame_done
);

    localparam int c_pw = (BPC > 1) ? $clog2(BPC) : 1;
    localparam int c_tw = $clog2(BASE_OE << (BPC - 1)) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [RW-1:0]       r_row;
    logic [CW-1:0]       r_col;
    logic                r_phase;
    logic [c_pw-1:0]     r_plane;
    logic [2:0]          r_rgb0;
    logic [2:0]          r_rgb1;
    logic [RW-1:0]       r_row_out;
    logic                r_frame_done;

    logic                w_pclk;
    logic                w_latch;
    logic                w_noe;
    logic [RW+CW-1:0]    w_addr;
    logic [CW-1:0]       w_col_nxt;
    logic                w_oe_start;
    logic                w_oe_done;
    logic [c_tw-1:0]     w_oe_load;
    logic                w_last_col;
    logic                w_last_plane;
    logic                w_last_row;

    assign w_col_nxt    = r_col + CW'(1);
    assign w_last_col   = (r_col == CW'(COLS - 1));
    assign w_last_plane = (r_plane == c_pw'(BPC - 1));
    assign w_last_row   = (r_row == RW'(ROWS_HALF - 1));
    assign w_oe_load    = c_tw'(BASE_OE) << r_plane;

    led_oe_timer #(
        .TW(c_tw)
    ) u_oe_timer (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_oe_start),
        .i_load  (w_oe_load),
        .o_done  (w_oe_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pclk      = 1'b0;
        w_latch     = 1'b0;
        w_noe       = 1'b1;
        w_oe_start  = 1'b0;
        w_addr      = {r_row, {CW{1'b0}}};
        case (r_state)
            ST_IDLE: begin
                if (init) w_state_nxt = ST_PREFETCH;
            end
            ST_PREFETCH: begin
                w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Address runs one column ahead so the read data lands on the next even cycle.
                w_pclk = r_phase;
                w_addr = {r_row, w_col_nxt};
                if (r_phase && w_last_col) w_state_nxt = ST_BLANK;
            end
            ST_BLANK: begin
                w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                w_latch     = 1'b1;
                w_oe_start  = 1'b1;
                w_state_nxt = ST_DISPLAY;
            end
            ST_DISPLAY: begin
                w_noe = 1'b0;
                if (w_oe_done) begin
                    if (w_last_plane && w_last_row && !init) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_PREFETCH;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_phase      <= 1'b0;
            r_plane      <= '0;
            r_rgb0       <= '0;
            r_rgb1       <= '0;
            r_row_out    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_SHIFT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) begin
                        r_col <= w_col_nxt;
                    end else begin
                        r_rgb0 <= plane_rgb(pix_top, 32'(r_plane));
                        r_rgb1 <= plane_rgb(pix_bot, 32'(r_plane));
                    end
                end
                ST_BLANK: begin
                    // Row address moves while the panel is still blanked.
                    r_row_out <= r_row;
                end
                ST_DISPLAY: begin
                    if (w_oe_done) begin
                        if (!w_last_plane) begin
                            r_plane <= r_plane + c_pw'(1);
                        end else begin
                            r_plane      <= '0;
                            r_row        <= w_last_row ? '0 : r_row + RW'(1);
                            r_frame_done <= w_last_row;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_addr   = w_addr;
    assign PCLK       = w_pclk;
    assign RGB0       = r_rgb0;
    assign RGB1       = r_rgb1;
    assign LATCH      = w_latch;
    assign NOE        = w_noe;
    assign ROW        = r_row_out;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_panel_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_panel_scan_ctrl
// Description : Panel-model scoreboard and directed scenarios for the scan
//               controller on a 4x2 (x2 banks) panel with two bit-planes.
// Revision    : 1.0  initial release
// ============================================================================
module tb_led_panel_scan_ctrl;

    localparam int COLS      = 4;
    localparam int ROWS_HALF = 2;
    localparam int BPC       = 2;
    localparam int BASE_OE   = 2;
    localparam int CW        = $clog2(COLS);
    localparam int RW        = $clog2(ROWS_HALF);
    localparam int NPIX      = COLS * ROWS_HALF;

    logic             clk = 1'b0;
    logic             rst;
    logic             init;
    logic [RW+CW-1:0] mem_addr;
    logic [11:0]      pix_top;
    logic [11:0]      pix_bot;
    logic             PCLK;
    logic [2:0]       RGB0;
    logic [2:0]       RGB1;
    logic             LATCH;
    logic             NOE;
    logic [RW-1:0]    ROW;
    logic             frame_done;

    led_panel_scan_ctrl #(
        .COLS      (COLS),
        .ROWS_HALF (ROWS_HALF),
        .BPC       (BPC),
        .BASE_OE   (BASE_OE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .mem_addr   (mem_addr),
        .pix_top    (pix_top),
        .pix_bot    (pix_bot),
        .PCLK       (PCLK),
        .RGB0       (RGB0),
        .RGB1       (RGB1),
        .LATCH      (LATCH),
        .NOE        (NOE),
        .ROW        (ROW),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Dual-bank frame buffer with one-cycle read latency.
    logic [11:0] fb_top [NPIX];
    logic [11:0] fb_bot [NPIX];
    always @(posedge clk) begin
        pix_top <= fb_top[mem_addr];
        pix_bot <= fb_bot[mem_addr];
    end

    logic rst_q  = 1'b0;
    logic init_q = 1'b0;
    always @(posedge clk) begin
        rst_q  <= rst;
        init_q <= init;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] exp_rgb(input logic [11:0] pix, input int p);
        int r, g, b;
        r = (int'(pix) >> (8 + p)) & 1;
        g = (int'(pix) >> (4 + p)) & 1;
        b = (int'(pix) >> p) & 1;
        return 3'(r * 4 + g * 2 + b);
    endfunction

    // Panel model state
    int          exp_row = 0, exp_plane = 0;
    int          pulses = 0, last_pulses = 0, latches_since = 0;
    int          low_run = 0, high_run = 0, fd_count = 0, total_latch = 0;
    bit          cont = 0, prev_noe = 1, prev_pclk = 0, end_frame, exp_fd_now;
    logic [RW-1:0] prev_row = '0;
    logic [2:0]  cap_top [COLS];
    logic [2:0]  cap_bot [COLS];
    logic [2:0]  lat_top [COLS];
    logic [2:0]  lat_bot [COLS];
    int          run_q[$];
    int          row_q[$];

    always @(negedge clk) begin
        if (!rst_q) begin
            chk("reset_noe", NOE, 1);
            chk("reset_latch", LATCH, 0);
            chk("reset_pclk", PCLK, 0);
            chk("reset_row", ROW, 0);
            chk("reset_rgb", {RGB0, RGB1}, 0);
            chk("reset_addr", mem_addr, 0);
            chk("reset_frame_done", frame_done, 0);
            exp_row = 0; exp_plane = 0; pulses = 0; latches_since = 0;
            low_run = 0; high_run = 0; cont = 0;
        end else begin
            chk("latch_during_display", 32'(LATCH & ~NOE), 0);
            chk("pclk_during_display", 32'(PCLK & ~NOE), 0);
            if (ROW != prev_row) chk("row_change_blanked", {NOE, prev_noe}, 2'b11);
            if (PCLK && !prev_pclk) begin
                if (pulses < COLS) begin
                    cap_top[pulses] = RGB0;
                    cap_bot[pulses] = RGB1;
                end
                pulses++;
            end
            if (LATCH) begin
                chk("pclk_pulses_per_line", pulses, COLS);
                for (int c = 0; c < COLS; c++) begin
                    chk("rgb0_image", cap_top[c], exp_rgb(fb_top[exp_row * COLS + c], exp_plane));
                    chk("rgb1_image", cap_bot[c], exp_rgb(fb_bot[exp_row * COLS + c], exp_plane));
                    lat_top[c] = cap_top[c];
                    lat_bot[c] = cap_bot[c];
                end
                last_pulses = pulses;
                pulses = 0;
                latches_since++;
                total_latch++;
            end
            exp_fd_now = 0;
            if (!NOE) begin
                if (prev_noe) begin
                    if (cont) chk("blank_gap", high_run, 2 * COLS + 3);
                    chk("one_latch_per_display", latches_since, 1);
                    latches_since = 0;
                    row_q.push_back(int'(ROW));
                    low_run = 0;
                end
                low_run++;
                chk("row_during_display", ROW, exp_row);
            end else begin
                if (!prev_noe) begin
                    chk("display_len", low_run, BASE_OE << exp_plane);
                    run_q.push_back(low_run);
                    end_frame  = (exp_plane == BPC - 1) && (exp_row == ROWS_HALF - 1);
                    exp_fd_now = end_frame;
                    if (exp_plane < BPC - 1) begin
                        exp_plane++;
                    end else begin
                        exp_plane = 0;
                        exp_row   = (exp_row + 1) % ROWS_HALF;
                    end
                    cont = !end_frame || init_q;
                    if (cont) chk("prefetch_addr", mem_addr, exp_row * COLS);
                    high_run = 0;
                end
                high_run++;
            end
            chk("frame_done", frame_done, exp_fd_now);
            if (frame_done) fd_count++;
        end
        prev_noe  = NOE;
        prev_pclk = PCLK;
        prev_row  = ROW;
    end

    task automatic wait_sig(input int sel, input int budget, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk); #1;
            case (sel)
                0:       hit = frame_done;
                1:       hit = LATCH;
                default: hit = !NOE;
            endcase
        end
        chk({"wait_", name}, 32'(hit), 1);
    endtask

    task automatic check_frame_seq(input string tag);
        int exp_runs [4] = '{2, 4, 2, 4};
        int exp_rows [4] = '{0, 0, 1, 1};
        chk({tag, "_display_count"}, run_q.size(), 4);
        chk({tag, "_row_count"}, row_q.size(), 4);
        for (int i = 0; i < 4 && i < run_q.size(); i++)
            chk({tag, "_display_len"}, run_q[i], exp_runs[i]);
        for (int i = 0; i < 4 && i < row_q.size(); i++)
            chk({tag, "_row_seq"}, row_q[i], exp_rows[i]);
        chk({tag, "_frame_done_count"}, fd_count, 1);
    endtask

    task automatic clear_log();
        run_q.delete();
        row_q.delete();
        fd_count = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b0;
        init = 1'b0;
        for (int i = 0; i < NPIX; i++) begin
            fb_top[i] = 12'hF0F;
            fb_bot[i] = 12'h0F0;
        end
        @(negedge clk); #1;
        init = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b1;

        // Plane 0 of a uniform image: magenta top, green bottom.
        wait_sig(1, 100, "first_latch");
        chk("t2_pulses", last_pulses, 4);
        for (int c = 0; c < COLS; c++) begin
            chk("t2_rgb0", lat_top[c], 3'b101);
            chk("t2_rgb1", lat_bot[c], 3'b010);
        end

        wait_sig(0, 200, "frame1_done");
        check_frame_seq("t4");
        chk("t4_latch_count", total_latch, 4);
        chk("t4_restart_addr", mem_addr, 0);

        // Drop init at the start of a frame; the frame still completes.
        clear_log();
        init = 1'b0;
        wait_sig(0, 200, "frame2_done");
        check_frame_seq("t5");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("t5_idle", {NOE, PCLK, LATCH}, 3'b100);
        end

        // Random image, continuous scanning.
        for (int i = 0; i < NPIX; i++) begin
            fb_top[i] = 12'($urandom);
            fb_bot[i] = 12'($urandom);
        end
        clear_log();
        init = 1'b1;
        wait_sig(0, 200, "frame3_done");
        check_frame_seq("t4b");

        // Reset in the middle of row 1 plane 0 display.
        wait_sig(1, 100, "latch_a");
        wait_sig(1, 100, "latch_b");
        wait_sig(1, 100, "latch_c");
        wait_sig(2, 100, "display_row1");
        chk("t6_row_before", ROW, 1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("t6_noe_after", NOE, 1);
        chk("t6_row_after", ROW, 0);
        rst = 1'b1;
        clear_log();
        wait_sig(0, 200, "frame_after_reset");
        check_frame_seq("t6");

        init = 1'b0;
        clear_log();
        wait_sig(0, 200, "final_frame");
        repeat (5) @(negedge clk);
        #1;
        chk("final_idle_noe", NOE, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
